// File: rtl/mod11_count_checker.sv
// Sequence checker for a loadable mod-11 counter.
// Tracks the counter, flags skips/illegal values and counts wraps.
module mod11_count_checker #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic [3:0]       count_in,
    input  logic             ld_enb_in,
    input  logic [3:0]       ld_in,
    output logic [1:0]       state,
    output logic             in_sync,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] CNT_ONE = 1;

    state_t     cur_st;
    state_t     nxt_st;
    logic [3:0] prev_cnt;
    logic [3:0] prev_ld;
    logic       prev_ld_enb;
    logic [3:0] expected;
    logic       mismatch;
    logic       is_wrap;
    logic       err_nxt;
    logic       wrap_nxt;

    always_comb begin
        expected = prev_ld_enb ? prev_ld :
                   ((prev_cnt == 4'd10) ? 4'd0 : prev_cnt + 4'd1);
        // an out-of-range load is an error even if the counter echoes it
        mismatch = (count_in != expected)
                || (count_in > 4'd10)
                || (prev_ld_enb && (prev_ld > 4'd10));
        is_wrap  = (prev_cnt == 4'd10) && !prev_ld_enb
                && (count_in == 4'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st   = cur_st;
        err_nxt  = 1'b0;
        wrap_nxt = 1'b0;
        if (!chk_en) begin
            nxt_st = IDLE;
        end else begin
            unique case (cur_st)
                IDLE: nxt_st = ACQUIRE;
                ACQUIRE: begin
                    if (count_in > 4'd10) begin
                        nxt_st  = FAULT;
                        err_nxt = 1'b1;
                    end else begin
                        nxt_st = TRACK;
                    end
                end
                TRACK: begin
                    if (mismatch) begin
                        nxt_st  = FAULT;
                        err_nxt = 1'b1;
                    end else begin
                        wrap_nxt = is_wrap;
                    end
                end
                FAULT: nxt_st = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt    <= 4'd0;
            prev_ld     <= 4'd0;
            prev_ld_enb <= 1'b0;
            err_pulse   <= 1'b0;
            wrap_pulse  <= 1'b0;
            err_cnt     <= '0;
            wrap_cnt    <= '0;
        end else begin
            prev_cnt    <= count_in;
            prev_ld     <= ld_in;
            prev_ld_enb <= ld_enb_in;
            err_pulse   <= err_nxt;
            wrap_pulse  <= wrap_nxt;
            if (err_nxt && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            if (wrap_nxt && (wrap_cnt != CNT_MAX)) begin
                wrap_cnt <= wrap_cnt + CNT_ONE;
            end
        end
    end

    assign state   = cur_st;
    assign in_sync = (cur_st == TRACK);

endmodule

// File: tb/tb_mod11_count_checker.sv
// Scoreboard bench for mod11_count_checker: directed scenarios
// followed by random traffic against a behavioural model.
module tb_mod11_count_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_en;
    logic [3:0] count_in;
    logic       ld_enb_in;
    logic [3:0] ld_in;

    logic [1:0] state, state2;
    logic       in_sync, in_sync2;
    logic       err_pulse, err_pulse2;
    logic       wrap_pulse, wrap_pulse2;
    logic [7:0] err_cnt, wrap_cnt;
    logic [1:0] err_cnt2, wrap_cnt2;

    mod11_count_checker #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en),
        .count_in(count_in), .ld_enb_in(ld_enb_in), .ld_in(ld_in),
        .state(state), .in_sync(in_sync),
        .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    mod11_count_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .chk_en(chk_en),
        .count_in(count_in), .ld_enb_in(ld_enb_in), .ld_in(ld_in),
        .state(state2), .in_sync(in_sync2),
        .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2),
        .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int sync;
        int ep;
        int wp;
        int ec;
        int wc;
        int ec2;
        int wc2;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // behavioural reference state
    int m_st, m_pcnt, m_ple, m_pld;
    int m_ec, m_wc, m_ec2, m_wc2;
    int gen_cnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pcnt = 0; m_ple = 0; m_pld = 0;
        m_ec = 0; m_wc = 0; m_ec2 = 0; m_wc2 = 0;
    endtask

    task automatic step(input int en, input int c, input int le, input int ld);
        int   nxt_val;
        int   ns;
        int   err;
        int   wrp;
        exp_t e;
        @(negedge clk);
        chk_en    = (en != 0);
        count_in  = c[3:0];
        ld_enb_in = (le != 0);
        ld_in     = ld[3:0];
        nxt_val = (m_ple != 0) ? m_pld : ((m_pcnt == 10) ? 0 : (m_pcnt + 1) % 16);
        ns = m_st; err = 0; wrp = 0;
        if (en == 0) ns = 0;
        else if (m_st == 0) ns = 1;
        else if (m_st == 1) begin
            if (c > 10) begin ns = 3; err = 1; end
            else ns = 2;
        end else if (m_st == 2) begin
            if (c > 10 || c != nxt_val || (m_ple != 0 && m_pld > 10)) begin
                ns = 3; err = 1;
            end else begin
                wrp = (m_pcnt == 10 && m_ple == 0 && c == 0) ? 1 : 0;
            end
        end else ns = 1;
        if (err != 0) begin
            if (m_ec < 255) m_ec++;
            if (m_ec2 < 3) m_ec2++;
        end
        if (wrp != 0) begin
            if (m_wc < 255) m_wc++;
            if (m_wc2 < 3) m_wc2++;
        end
        m_st = ns; m_pcnt = c; m_ple = le; m_pld = ld;
        e.st = ns; e.sync = (ns == 2) ? 1 : 0; e.ep = err; e.wp = wrp;
        e.ec = m_ec; e.wc = m_wc; e.ec2 = m_ec2; e.wc2 = m_wc2;
        q.push_back(e);
    endtask

    task automatic rnd_step();
        int en, c, le, ld;
        en = ($urandom_range(0, 31) != 0) ? 1 : 0;
        c  = gen_cnt;
        if ($urandom_range(0, 19) == 0) c = $urandom_range(0, 15);
        le = ($urandom_range(0, 7) == 0) ? 1 : 0;
        ld = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15)
                                          : $urandom_range(0, 10);
        step(en, c, le, ld);
        gen_cnt = (le != 0) ? ld : ((c == 10) ? 0 : (c + 1) % 16);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_in_sync"}, in_sync, 0);
        chk({tag, "_err_pulse"}, err_pulse, 0);
        chk({tag, "_wrap_pulse"}, wrap_pulse, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_wrap_cnt"}, wrap_cnt, 0);
        chk({tag, "_err_cnt2"}, err_cnt2, 0);
    endtask

    // monitor: one expected entry per stimulated edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", state, e.st);
                chk("in_sync", in_sync, e.sync);
                chk("err_pulse", err_pulse, e.ep);
                chk("wrap_pulse", wrap_pulse, e.wp);
                chk("err_cnt", err_cnt, e.ec);
                chk("wrap_cnt", wrap_cnt, e.wc);
                chk("err_cnt_w2", err_cnt2, e.ec2);
                chk("wrap_cnt_w2", wrap_cnt2, e.wc2);
                chk("pulse_excl", int'(err_pulse && wrap_pulse), 0);
            end
        end
    end

    initial begin
        rst = 1'b0; chk_en = 1'b0; count_in = 4'd0;
        ld_enb_in = 1'b0; ld_in = 4'd0;
        model_reset();
        gen_cnt = 0;
        #3;
        chk_zero("reset");
        @(posedge clk); #2 rst = 1'b1;

        // legal stream with one wrap
        for (int i = 0; i <= 10; i++) step(1, i, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        // skip 4 -> 6, then resync
        step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
        step(1, 6, 0, 0); step(1, 7, 0, 0); step(1, 8, 0, 0);
        step(1, 9, 0, 0);
        // legal load of 3 at count 7
        step(1, 10, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
        step(1, 5, 0, 0); step(1, 6, 0, 0); step(1, 7, 1, 3);
        step(1, 3, 0, 0); step(1, 4, 0, 0);
        // load of the value it would count to anyway
        step(1, 5, 1, 6); step(1, 6, 0, 0);
        // illegal load
        step(1, 7, 1, 12); step(1, 12, 0, 0); step(1, 0, 0, 0);
        step(1, 1, 0, 0); step(1, 2, 0, 0);
        // out-of-range value in TRACK then in ACQUIRE
        step(1, 11, 0, 0); step(1, 0, 0, 0); step(1, 11, 0, 0);
        step(1, 0, 0, 0); step(1, 1, 0, 0);
        // repeated faults drive the narrow counter into saturation
        for (int i = 0; i < 12; i++) step(1, 11, 0, 0);
        // disable mid-track
        step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 2, 0, 0);
        step(0, 9, 0, 0); step(1, 4, 0, 0); step(1, 5, 0, 0);
        step(1, 6, 0, 0);
        gen_cnt = 7;

        for (int i = 0; i < 600; i++) rnd_step();

        // async reset between edges while tracking
        for (int i = 0; i < 4; i++) step(1, i, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i <= 10; i++) step(1, i, 0, 0);
        step(1, 0, 0, 0);
        gen_cnt = 1;
        for (int i = 0; i < 100; i++) rnd_step();

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod11_count_checker.md
MOD11_COUNT_CHECKER -- requirements
Module: mod11_count_checker

Interface
REQ-001 SHALL have parameter ERR_W, default 8, meaning width of the saturating error and wrap counters.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low; assertion (0) clears all state immediately.
REQ-004 SHALL have port chk_en  input  1  checking enable; 0 forces IDLE.
REQ-005 SHALL have port count_in  input  4  monitored mod-11 counter value, sampled each rising edge.
REQ-006 SHALL have port ld_enb_in  input  1  monitored counter's load enable, sampled with count_in.
REQ-007 SHALL have port ld_in  input  4  monitored counter's load value, sampled with count_in.
REQ-008 SHALL have port state  output  2  checker state: IDLE=0, ACQUIRE=1, TRACK=2, FAULT=3.
REQ-009 SHALL have port in_sync  output  1  high while state==TRACK.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag for a detected sequence error.
REQ-011 SHALL have port wrap_pulse  output  1  one-cycle flag for an observed legal 10->0 wrap.
REQ-012 SHALL have port err_cnt  output  ERR_W  saturating count of err_pulse assertions.
REQ-013 SHALL have port wrap_cnt  output  ERR_W  saturating count of wrap_pulse assertions.

Function
REQ-014 SHALL register on every edge: prev_cnt<=count_in, prev_ld_enb<=ld_enb_in, prev_ld<=ld_in.
REQ-015 SHALL compute expected = prev_ld_enb ? prev_ld : (prev_cnt==10 ? 0 : prev_cnt+1); 4-bit, no wider arithmetic.
REQ-016 SHALL define mismatch = (count_in != expected) OR (count_in > 10).
REQ-017 SHALL treat an illegal load (prev_ld_enb=1 with prev_ld>10) as a mismatch in the following cycle, regardless of count_in.
REQ-018 IDLE: chk_en=1 -> ACQUIRE; otherwise stay; no comparisons, no pulses.
REQ-019 ACQUIRE: capture only, no comparison; next edge -> TRACK if count_in<=10, else FAULT with err_pulse.
REQ-020 TRACK: compare each edge; mismatch -> FAULT and err_pulse=1 next cycle; no mismatch -> stay.
REQ-021 FAULT: re-acquire; next edge -> ACQUIRE (one sample resynchronises); no further err_pulse while in FAULT.
REQ-022 chk_en=0 in any state SHALL force IDLE on the next edge and suppress err_pulse/wrap_pulse that edge; counters hold.
REQ-023 wrap_pulse SHALL assert one cycle after a TRACK-state sample where prev_cnt==10, prev_ld_enb=0, count_in==0.
REQ-024 err_pulse and wrap_pulse SHALL be registered outputs, latency exactly one clock after the offending sample edge; never both high.
REQ-025 err_cnt/wrap_cnt SHALL increment by 1 on the edge the respective pulse is set, and hold at 2^ERR_W-1 (no wrap).
REQ-026 A load of the current expected value SHALL be accepted as legal (no error).

Reset
REQ-027 rst=0 SHALL immediately set state=IDLE, in_sync=0, err_pulse=0, wrap_pulse=0, err_cnt=0, wrap_cnt=0, prev_* = 0.
REQ-028 rst deassertion mid-sequence SHALL restart from IDLE; first comparison occurs no earlier than the second edge after chk_en=1.

Verification
REQ-029 Reset then chk_en=1, count_in 0,1,...,10,0,1 legal stream -> in_sync=1 from the 2nd edge, wrap_pulse once, wrap_cnt=1, err_cnt=0.
REQ-030 In TRACK, count_in 4 then 6 (skip) -> err_pulse one cycle, state FAULT then ACQUIRE then TRACK, err_cnt=1.
REQ-031 In TRACK, ld_enb_in=1 ld_in=3 while count=7, next count_in=3 -> no error; ld_in=12 -> err_pulse next cycle.
REQ-032 count_in=11 while TRACK -> err_pulse, err_cnt increments; count_in=11 while ACQUIRE -> FAULT.
REQ-033 ERR_W=2, force 5 faults -> err_cnt saturates at 3.
REQ-034 rst=0 asserted between edges in TRACK -> all outputs 0 and state IDLE before the next edge.
